fios_final_sub: RTL and testbench
=================================

FIOS_FINAL_SUB -- requirements
Module: fios_final_sub

Interface
REQ-001 Parameter s, default 8: number of 17-bit result words per FIOS product; s >= 2.
REQ-002 Parameter OUT_REG, default 1: 1 registers out_data_o/out_last_o; 0 drives them combinationally from the buffer read.
REQ-003 clock_i  in  1  single clock, all state on rising edge.
REQ-004 reset_n_i  in  1  reset, asynchronous, active-low.
REQ-005 p_i  in  s*17  modulus p, word k at bits [17k+16:17k]; held stable while busy_o=1.
REQ-006 res_push_i  in  1  one FIOS result word valid this cycle (driven by RES_push_o of the FIOS top).
REQ-007 res_i  in  17  FIOS result word, least significant word first.
REQ-008 done_i  in  1  FIOS product complete (driven by done_o of the FIOS top).
REQ-009 out_valid_o  out  1  reduced word available.
REQ-010 out_ready_i  in  1  downstream accepts the word.
REQ-011 out_data_o  out  17  reduced word, least significant word first.
REQ-012 out_last_o  out  1  marks word s-1.
REQ-013 busy_o  out  1  high in any state other than IDLE.
REQ-014 err_o  out  1  sticky protocol error flag.

Function
REQ-015 The FSM states SHALL be IDLE, COLLECT, DRAIN; reset state IDLE.
REQ-016 IDLE->COLLECT on the first res_push_i; that word is captured as word 0.
REQ-017 In COLLECT, each push SHALL store res_i at index wcnt, compute d = res_i - p[wcnt] - borrow mod 2^17, store d, update borrow, and increment wcnt.
REQ-018 The borrow SHALL be cleared on entry to COLLECT; subtraction is exact 17-bit serial, with no carry beyond word s-1.
REQ-019 COLLECT->DRAIN on done_i when wcnt==s, counting a push in the same cycle as done_i.
REQ-020 done_i with wcnt!=s SHALL set err_o and return to IDLE with no output.
REQ-021 A push with wcnt==s SHALL set err_o and be dropped.
REQ-022 sel SHALL latch on entry to DRAIN: sel = ~borrow. sel=1 outputs the diff buffer (RES >= p); sel=0 outputs the RES buffer.
REQ-023 out_valid_o SHALL assert the first cycle after the DRAIN entry edge, with rcnt=0.
REQ-024 A word transfers on out_valid_o & out_ready_i; rcnt then increments.
REQ-025 out_data_o and out_last_o SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-026 out_last_o=1 iff rcnt==s-1; the transfer of that word returns the FSM to IDLE and deasserts out_valid_o the next cycle.
REQ-027 res_push_i or done_i during DRAIN SHALL set err_o and be ignored.
REQ-028 done_i in IDLE SHALL be ignored.
REQ-029 Throughput: one new product accepted per s+1+s cycles minimum with out_ready_i held high.

Reset
REQ-030 reset_n_i low SHALL asynchronously force IDLE, wcnt=rcnt=0, borrow=0, sel=0, out_valid_o=0, out_last_o=0, out_data_o=0, busy_o=0, err_o=0.
REQ-031 Buffer contents are not reset; outputs never expose them before a complete COLLECT.
REQ-032 Reset asserted mid-COLLECT or mid-DRAIN SHALL discard the product; the next push after release starts a new product at word 0.
REQ-033 err_o SHALL be cleared only by reset.

Configuration
REQ-034 Macro FIOS_FINAL_SUB_EN defined: the diff buffer, borrow chain and sel are implemented per REQ-017/REQ-022.
REQ-035 Macro FIOS_FINAL_SUB_EN undefined: no diff buffer or borrow logic; DRAIN replays the RES buffer unmodified; p_i is unused; all handshake, error and timing behaviour is unchanged.

Verification (s=4, macro defined unless noted)
REQ-036 p=words{7,0,0,0x100}, RES=p+5={0xC,0,0,0x100}, then done -> out {5,0,0,0}, last on word 3, sel=1.
REQ-037 Same p, RES=p-1={6,0,0,0x100} -> out {6,0,0,0x100} unchanged, sel=0.
REQ-038 RES==p -> out {0,0,0,0}; word 0 = 0x1FFFF and rest 0 with p={1,0,0,0} -> out {0x1FFFE,0,0,0}.
REQ-039 out_ready_i low 3 cycles at word 1 -> out_data_o/out_last_o stable, no word lost or duplicated, busy_o high until word 3 accepted.
REQ-040 done_i after 3 pushes -> err_o=1, no out_valid_o; extra push during DRAIN -> err_o=1, output stream intact.
REQ-041 reset_n_i pulsed low after 2 pushes -> outputs cleared same cycle; next 4-push product reduces correctly; macro undefined -> REQ-036 stimulus outputs {0xC,0,0,0x100}.

Source files
------------

// File: rtl/fios_final_sub.sv
// Final conditional subtraction for a FIOS Montgomery product: collects s result words, streams RES or RES - p.
// Build option FIOS_FINAL_SUB_EN adds the diff buffer and borrow chain; without it the product is replayed unchanged.

module fios_final_sub #(
   parameter int s       = 8,
   parameter bit OUT_REG = 1'b1
) (
   input  logic            clock_i,
   input  logic            reset_n_i,
   input  logic [s*17-1:0] p_i,
   input  logic            res_push_i,
   input  logic [16:0]     res_i,
   input  logic            done_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [16:0]     out_data_o,
   output logic            out_last_o,
   output logic            busy_o,
   output logic            err_o
);

   // state   | meaning
   // IDLE    | waiting for word 0 of a new product
   // COLLECT | storing words and running the RES - p borrow chain
   // DRAIN   | streaming the selected buffer, least significant word first

   localparam int            CW    = $clog2(s + 1);
   localparam logic [CW-1:0] WORDS = CW'(s);
   localparam logic [CW-1:0] LAST  = CW'(s - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

   state_t        state;
   logic [CW-1:0] wcnt;
   logic [CW-1:0] rcnt;
   logic          borrow;
   logic          sel;
   logic          err;
   logic [16:0]   out_data_r;
   logic          out_last_r;
   logic [16:0]   res_buf [s];

   logic [CW-1:0] widx;
   logic [CW-1:0] wptr;
   logic [CW-1:0] wcnt_nxt;
   logic [CW-1:0] rd_idx;
   logic          push_ok;
   logic          drain_go;
   logic          borrow_nxt;
   logic          sel_entry;
   logic          rd_sel;
   logic [16:0]   rd_word;

   always_comb begin
      widx     = (state == IDLE) ? '0 : wcnt;
      wptr     = (widx < WORDS) ? widx : '0;
      push_ok  = res_push_i && ((state == IDLE) || ((state == COLLECT) && (wcnt != WORDS)));
      wcnt_nxt = push_ok ? widx + CW'(1) : widx;
      drain_go = (state == COLLECT) && done_i && (wcnt_nxt == WORDS);
   end

   always_ff @(posedge clock_i) begin
      if (push_ok) res_buf[wptr] <= res_i;
   end

`ifdef FIOS_FINAL_SUB_EN
   logic [16:0] diff_buf [s];
   logic [17:0] sub;

   always_comb begin
      sub        = {1'b0, res_i} - {1'b0, p_i[17*wptr +: 17]} - {17'd0, (state == COLLECT) && borrow};
      borrow_nxt = push_ok ? sub[17] : ((state == COLLECT) && borrow);
   end

   always_ff @(posedge clock_i) begin
      if (push_ok) diff_buf[wptr] <= sub[16:0];
   end

   assign rd_word = rd_sel ? diff_buf[rd_idx] : res_buf[rd_idx];
`else
   logic unused_in;

   assign borrow_nxt = 1'b0;
   assign unused_in  = ^{p_i, rd_sel};
   assign rd_word    = res_buf[rd_idx];
`endif

   // No final borrow means RES >= p, so the difference is the reduced result.
   assign sel_entry = ~borrow_nxt;
   assign rd_sel    = (OUT_REG && drain_go) ? sel_entry : sel;

   // Registered outputs preload the word that will be shown after the next edge.
   always_comb begin
      if (!OUT_REG)                    rd_idx = rcnt;
      else if (drain_go || rcnt == LAST) rd_idx = '0;
      else                             rd_idx = rcnt + CW'(1);
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state      <= IDLE;
         wcnt       <= '0;
         rcnt       <= '0;
         borrow     <= 1'b0;
         sel        <= 1'b0;
         err        <= 1'b0;
         out_data_r <= '0;
         out_last_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (res_push_i) begin
                  state  <= COLLECT;
                  wcnt   <= wcnt_nxt;
                  borrow <= borrow_nxt;
               end
            end
            COLLECT: begin
               if (res_push_i && !push_ok) err <= 1'b1;
               wcnt   <= wcnt_nxt;
               borrow <= borrow_nxt;
               if (done_i) begin
                  wcnt   <= '0;
                  borrow <= 1'b0;
                  if (drain_go) begin
                     state      <= DRAIN;
                     rcnt       <= '0;
                     sel        <= sel_entry;
                     out_data_r <= OUT_REG ? rd_word : '0;
                     out_last_r <= (LAST == '0);
                  end else begin
                     err   <= 1'b1;
                     state <= IDLE;
                  end
               end
            end
            DRAIN: begin
               if (res_push_i || done_i) err <= 1'b1;
               if (out_ready_i) begin
                  if (rcnt == LAST) begin
                     state      <= IDLE;
                     rcnt       <= '0;
                     sel        <= 1'b0;
                     out_data_r <= '0;
                     out_last_r <= 1'b0;
                  end else begin
                     rcnt       <= rcnt + CW'(1);
                     out_data_r <= rd_word;
                     out_last_r <= ((rcnt + CW'(1)) == LAST);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign out_valid_o = (state == DRAIN);
   assign busy_o      = (state != IDLE);
   assign err_o       = err;
   assign out_data_o  = OUT_REG ? out_data_r : (out_valid_o ? rd_word : '0);
   assign out_last_o  = OUT_REG ? out_last_r : (out_valid_o && (rcnt == LAST));

endmodule

// File: tb/tb_fios_final_sub.sv
// Bench for fios_final_sub (s=4): random products against a 68-bit arithmetic reference.
// Expected results follow FIOS_FINAL_SUB_EN the same way the design build does.

module tb_fios_final_sub;

   localparam int S = 4;

   logic          clock_i = 1'b0;
   logic          reset_n_i = 1'b0;
   logic [67:0]   p_i = '0;
   logic          res_push_i = 1'b0;
   logic [16:0]   res_i = '0;
   logic          done_i = 1'b0;
   logic          out_valid_o;
   logic          out_ready_i = 1'b0;
   logic [16:0]   out_data_o;
   logic          out_last_o;
   logic          busy_o;
   logic          err_o;

   int pass_cnt = 0;
   int total_cnt = 0;
   bit exp_err = 1'b0;

   fios_final_sub #(.s(S), .OUT_REG(1'b1)) dut (
      .clock_i     (clock_i),
      .reset_n_i   (reset_n_i),
      .p_i         (p_i),
      .res_push_i  (res_push_i),
      .res_i       (res_i),
      .done_i      (done_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_last_o  (out_last_o),
      .busy_o      (busy_o),
      .err_o       (err_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Whole-number view: the product is reduced iff RES >= p.
   function automatic logic [67:0] model(input logic [67:0] r, input logic [67:0] p);
      bit ge;
      ge = (r >= p);
`ifndef FIOS_FINAL_SUB_EN
      ge = 1'b0;
`endif
      return ge ? r - p : r;
   endfunction

   function automatic logic [67:0] rand68();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[67:0];
   endfunction

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   // done_mode: 0 = with last push, 1 = cycle after, 2 = none
   task automatic push_words(input logic [67:0] w, input int n, input int done_mode, input int gap_max);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, gap_max)) begin
            res_i = 17'($urandom());
            tick();
         end
         res_push_i = 1'b1;
         res_i      = w[17*i +: 17];
         done_i     = (done_mode == 0) && (i == n - 1);
         tick();
         res_push_i = 1'b0;
         done_i     = 1'b0;
      end
      if (done_mode == 1) begin
         done_i = 1'b1;
         tick();
         done_i = 1'b0;
      end
   endtask

   task automatic drain_check(input string tag, input logic [67:0] exp, input int stall_word,
                              input int stall_len, input bit rnd_ready, input bit inject);
      int idx = 0;
      int cyc = 0;
      int stall = 0;
      int first = -1;
      logic [17:0] held = '0;
      bit hold = 1'b0;
      while (idx < S && cyc < 100) begin
         res_push_i = 1'b0;
         done_i     = 1'b0;
         if (inject && cyc == 1) begin
            res_push_i = 1'b1;
            res_i      = 17'($urandom());
         end
         if (inject && cyc == 2) done_i = 1'b1;
         if (stall_word == idx && stall < stall_len) begin
            out_ready_i = 1'b0;
            stall++;
         end else begin
            out_ready_i = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
         end
         @(negedge clock_i);
         if (out_valid_o) begin
            if (first < 0) first = cyc;
            if (hold) chk({tag, "_hold"}, {14'd0, out_last_o, out_data_o}, {14'd0, held});
            if (out_ready_i) begin
               chk({tag, "_data"}, {15'd0, out_data_o}, {15'd0, exp[17*idx +: 17]});
               chk({tag, "_last"}, {31'd0, out_last_o}, {31'd0, idx == S - 1});
               chk({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
               idx++;
               hold = 1'b0;
            end else begin
               held = {out_last_o, out_data_o};
               hold = 1'b1;
            end
         end
         tick();
         cyc++;
      end
      res_push_i  = 1'b0;
      done_i      = 1'b0;
      out_ready_i = 1'b0;
      chk({tag, "_words"}, idx, S);
      chk({tag, "_lat"}, first, 0);
      @(negedge clock_i);
      chk({tag, "_vend"}, {31'd0, out_valid_o}, 32'd0);
      chk({tag, "_bend"}, {31'd0, busy_o}, 32'd0);
      chk({tag, "_err"}, {31'd0, err_o}, {31'd0, exp_err});
      tick();
   endtask

   task automatic do_reset(input string tag);
      reset_n_i = 1'b0;
      #1;
      chk({tag, "_valid"}, {31'd0, out_valid_o}, 32'd0);
      chk({tag, "_data"}, {15'd0, out_data_o}, 32'd0);
      chk({tag, "_last"}, {31'd0, out_last_o}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
      chk({tag, "_err"}, {31'd0, err_o}, 32'd0);
      tick();
      reset_n_i = 1'b1;
      exp_err   = 1'b0;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [67:0] p0, r, p;
      int dl;

      tick();
      do_reset("rst0");

      p0  = {17'h100, 17'h0, 17'h0, 17'h7};
      p_i = p0;
      r = {17'h100, 17'h0, 17'h0, 17'hC};
      push_words(r, 4, 0, 0);
      drain_check("gt", model(r, p0), -1, 0, 1'b0, 1'b0);

      r = {17'h100, 17'h0, 17'h0, 17'h6};
      push_words(r, 4, 0, 1);
      drain_check("lt", model(r, p0), -1, 0, 1'b0, 1'b0);

      push_words(p0, 4, 1, 0);
      drain_check("eq", model(p0, p0), -1, 0, 1'b0, 1'b0);

      p   = {17'h0, 17'h0, 17'h0, 17'h1};
      p_i = p;
      r   = {17'h0, 17'h0, 17'h0, 17'h1FFFF};
      push_words(r, 4, 1, 0);
      drain_check("top", model(r, p), -1, 0, 1'b0, 1'b0);

      p_i = p0;
      r   = {17'h100, 17'h0, 17'h0, 17'hC};
      push_words(r, 4, 0, 0);
      drain_check("stall", model(r, p0), 1, 3, 1'b0, 1'b0);

      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      @(negedge clock_i);
      chk("idle_done_busy", {31'd0, busy_o}, 32'd0);
      chk("idle_done_err", {31'd0, err_o}, 32'd0);
      tick();

      for (int n = 0; n < 24; n++) begin
         p  = rand68();
         dl = $urandom_range(0, 6);
         case ($urandom_range(0, 2))
            0:       r = rand68();
            1:       r = p + 68'(dl) - 68'd3;
            default: r = p;
         endcase
         p_i = p;
         push_words(r, 4, $urandom_range(0, 1), 2);
         drain_check("rnd", model(r, p), -1, 0, 1'b1, 1'b0);
      end

      // Short product: flagged, no output.
      push_words(rand68(), 3, 0, 1);
      exp_err = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock_i);
         chk("short_valid", {31'd0, out_valid_o}, 32'd0);
         tick();
      end
      chk("short_busy", {31'd0, busy_o}, 32'd0);
      chk("short_err", {31'd0, err_o}, 32'd1);
      p = rand68();
      p_i = p;
      r = rand68();
      push_words(r, 4, 0, 0);
      drain_check("sticky", model(r, p), -1, 0, 1'b1, 1'b0);

      do_reset("rst1");
      r = rand68();
      push_words(r, 4, 2, 0);
      res_push_i = 1'b1;
      res_i      = 17'($urandom());
      done_i     = 1'b1;
      tick();
      res_push_i = 1'b0;
      done_i     = 1'b0;
      exp_err    = 1'b1;
      drain_check("extra", model(r, p), -1, 0, 1'b0, 1'b0);

      do_reset("rst2");
      r = rand68();
      push_words(r, 4, 0, 0);
      exp_err = 1'b1;
      drain_check("inject", model(r, p), 0, 4, 1'b0, 1'b1);

      do_reset("rst3");
      push_words(rand68(), 2, 2, 0);
      reset_n_i = 1'b0;
      #1;
      chk("midc_busy", {31'd0, busy_o}, 32'd0);
      chk("midc_valid", {31'd0, out_valid_o}, 32'd0);
      tick();
      reset_n_i = 1'b1;
      exp_err   = 1'b0;
      tick();
      r = rand68();
      push_words(r, 4, 0, 1);
      drain_check("midc", model(r, p), -1, 0, 1'b1, 1'b0);

      push_words(rand68(), 4, 0, 0);
      chk("midd_valid1", {31'd0, out_valid_o}, 32'd1);
      reset_n_i = 1'b0;
      #1;
      chk("midd_valid0", {31'd0, out_valid_o}, 32'd0);
      chk("midd_data", {15'd0, out_data_o}, 32'd0);
      chk("midd_last", {31'd0, out_last_o}, 32'd0);
      chk("midd_busy", {31'd0, busy_o}, 32'd0);
      tick();
      reset_n_i = 1'b1;
      tick();
      p_i = p0;
      r   = {17'h100, 17'h0, 17'h0, 17'hC};
      push_words(r, 4, 0, 0);
      drain_check("midd", model(r, p0), -1, 0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
